icache: RTL and testbench

Direct-mapped instruction cache between the instruction-fetch stage and the memory controller's instruction port. Hits return in one cycle. Misses issue a single-cycle fetch request to the memory controller, wait for the 32-bit instruction, fill the line and forward the instruction. On a pipeline clear, it abandons the pending fetch without corrupting the memory-controller handshake.

---
 rtl/icache_if.sv | 25 ++
 rtl/icache.sv | 118 +++++++++++
 tb/tb_icache.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Handshake bundle between the instruction cache, the fetch stage and the
// memory controller's instruction port.
interface icache_if;
  logic        iIF_En;
  logic [31:0] iIF_Pc;
  logic        oIF_Rdy;
  logic        oIF_En;
  logic [31:0] oIF_Ins;
  logic        iClr;
  logic        iFlush;
  logic        oMC_En;
  logic [31:0] oMC_Pc;
  logic        iMC_En;
  logic [31:0] iMC_Ins;

  modport slave (
    input  iIF_En, iIF_Pc, iClr, iFlush, iMC_En, iMC_Ins,
    output oIF_Rdy, oIF_En, oIF_Ins, oMC_En, oMC_Pc
  );

  modport master (
    output iIF_En, iIF_Pc, iClr, iFlush, iMC_En, iMC_Ins,
    input  oIF_Rdy, oIF_En, oIF_Ins, oMC_En, oMC_Pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding
// memory fetch; a pipeline clear turns a pending miss into a silent line fill.
module icache #(
  parameter int IDX_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  icache_if.slave  bus
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;

  state_t             state, state_nxt;
  logic [LINES-1:0]   valid, valid_nxt;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES];
  logic [31:2]        mpc, mpc_nxt;

  logic [IDX_W-1:0]   req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit, accept, fill;
  logic               if_en_nxt, mc_en_nxt;
  logic [31:0]        if_ins_nxt, mc_pc_nxt;

  assign req_idx  = bus.iIF_Pc[IDX_W+1:2];
  assign req_tag  = bus.iIF_Pc[31:IDX_W+2];
  assign fill_idx = mpc[IDX_W+1:2];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign accept   = (state == IDLE) && bus.iIF_En && !bus.iClr;
  // A return is only meaningful while a fetch is outstanding; strays in IDLE are dropped.
  assign fill     = (state != IDLE) && bus.iMC_En;

  assign bus.oIF_Rdy = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else if (en)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !hit) state_nxt = MISS;
      MISS: begin
        if (bus.iMC_En)    state_nxt = IDLE;
        else if (bus.iClr) state_nxt = DROP;
      end
      DROP: if (bus.iMC_En) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_en_nxt  = 1'b0;
    mc_en_nxt  = 1'b0;
    if_ins_nxt = bus.oIF_Ins;
    mc_pc_nxt  = bus.oMC_Pc;
    mpc_nxt    = mpc;
    // Flush clears everything, but a fill landing in the same cycle keeps its line.
    valid_nxt  = bus.iFlush ? '0 : valid;
    if (fill)
      valid_nxt[fill_idx] = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            if_en_nxt  = 1'b1;
            if_ins_nxt = data_mem[req_idx];
          end else begin
            mc_en_nxt  = 1'b1;
            mc_pc_nxt  = {bus.iIF_Pc[31:2], 2'b00};
            mpc_nxt    = bus.iIF_Pc[31:2];
          end
        end
      end
      MISS: begin
        if (bus.iMC_En && !bus.iClr) begin
          if_en_nxt  = 1'b1;
          if_ins_nxt = bus.iMC_Ins;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.oIF_En  <= 1'b0;
      bus.oIF_Ins <= '0;
      bus.oMC_En  <= 1'b0;
      bus.oMC_Pc  <= '0;
      mpc         <= '0;
      valid       <= '0;
    end else if (en) begin
      bus.oIF_En  <= if_en_nxt;
      bus.oIF_Ins <= if_ins_nxt;
      bus.oMC_En  <= mc_en_nxt;
      bus.oMC_Pc  <= mc_pc_nxt;
      mpc         <= mpc_nxt;
      valid       <= valid_nxt;
    end
  end

  // Tag and data arrays carry no reset; valid alone decides whether they are trusted.
  always_ff @(posedge clk) begin
    if (en && fill) begin
      tag_mem[fill_idx]  <= mpc[31:IDX_W+2];
      data_mem[fill_idx] <= bus.iMC_Ins;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: fetch vectors from a table plus hand-built clear, flush,
// stall and reset sequences; returned instructions are scoreboarded.
module tb_icache;

  logic clk = 1'b0;
  logic rst;
  logic en;

  icache_if ifc ();

  icache #(.IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          exp_miss;
    int          lat;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] sb [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mc_count = 0;
  int          mc0;

  function automatic logic [31:0] memval(input logic [31:0] pc);
    case (pc)
      32'h100: memval = 32'hDEADBEEF;
      32'h200: memval = 32'h12345678;
      default: memval = {pc[15:0], ~pc[15:0]} ^ 32'h5A5A3C3C;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: every oIF_En must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ifc.oMC_En) mc_count++;
    if (ifc.oIF_En) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL spurious_if_en: got oIF_En=1 ins=%h, required no output (t=%0t)",
                 ifc.oIF_Ins, $time);
      end else begin
        checkOutput("if_ins", ifc.oIF_Ins, sb.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rst && en)
      assert (!(ifc.iIF_En && !ifc.oIF_Rdy))
        else $error("[TB] protocol violation: iIF_En while oIF_Rdy=0");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input bit clr, input bit push);
    ifc.iIF_En = 1'b1;
    ifc.iIF_Pc = pc;
    ifc.iClr   = clr;
    if (push) sb.push_back(memval(pc));
    step();
    ifc.iIF_En = 1'b0;
    ifc.iClr   = 1'b0;
  endtask

  task automatic mcReturn(input logic [31:0] data, input bit clr, input bit flush);
    ifc.iMC_En  = 1'b1;
    ifc.iMC_Ins = data;
    ifc.iClr    = clr;
    ifc.iFlush  = flush;
    step();
    ifc.iMC_En  = 1'b0;
    ifc.iClr    = 1'b0;
    ifc.iFlush  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input bit exp_miss, input int lat);
    int m0;
    m0 = mc_count;
    applyStimulus(pc, 1'b0, 1'b1);
    checkOutput("mc_req_count", 32'(mc_count - m0), 32'(exp_miss));
    if (exp_miss) begin
      checkOutput("mc_pc", ifc.oMC_Pc, {pc[31:2], 2'b00});
      checkOutput("rdy_in_miss", 32'(ifc.oIF_Rdy), 32'd0);
      repeat (lat - 1) step();
      mcReturn(memval(pc), 1'b0, 1'b0);
      checkOutput("rdy_after_ret", 32'(ifc.oIF_Rdy), 32'd1);
    end
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h100, 1'b1, 4};
    vecs[1] = '{32'h100, 1'b0, 0};
    vecs[2] = '{32'h180, 1'b1, 2};
    vecs[3] = '{32'h100, 1'b1, 3};
    vecs[4] = '{32'h180, 1'b1, 1};
    vecs[5] = '{32'h104, 1'b1, 1};
    vecs[6] = '{32'h104, 1'b0, 0};
    vecs[7] = '{32'h100, 1'b1, 2};
    vecs[8] = '{32'h100, 1'b0, 0};

    rst = 1'b0;
    en  = 1'b1;
    ifc.iIF_En = 1'b0; ifc.iIF_Pc = '0; ifc.iClr = 1'b0; ifc.iFlush = 1'b0;
    ifc.iMC_En = 1'b0; ifc.iMC_Ins = '0;
    step();
    step();
    checkOutput("rst_if_en",  32'(ifc.oIF_En), 32'd0);
    checkOutput("rst_if_ins", ifc.oIF_Ins, 32'd0);
    checkOutput("rst_mc_en",  32'(ifc.oMC_En), 32'd0);
    checkOutput("rst_mc_pc",  ifc.oMC_Pc, 32'd0);
    checkOutput("rst_rdy",    32'(ifc.oIF_Rdy), 32'd1);
    rst = 1'b1;
    step();

    for (int i = 0; i < 9; i++)
      fetch(vecs[i].pc, vecs[i].exp_miss, vecs[i].lat);

    // Back-to-back hits, one accepted every cycle
    mc0 = mc_count;
    ifc.iIF_En = 1'b1;
    ifc.iIF_Pc = 32'h100; sb.push_back(memval(32'h100)); step();
    ifc.iIF_Pc = 32'h104; sb.push_back(memval(32'h104)); step();
    ifc.iIF_Pc = 32'h100; sb.push_back(memval(32'h100)); step();
    ifc.iIF_En = 1'b0;
    checkOutput("b2b_no_mc", 32'(mc_count - mc0), 32'd0);
    checkOutput("b2b_drained", 32'(sb.size()), 32'd0);
    checkOutput("b2b_rdy", 32'(ifc.oIF_Rdy), 32'd1);

    // Request and clear in the same IDLE cycle: discarded
    mc0 = mc_count;
    applyStimulus(32'h400, 1'b1, 1'b0);
    step();
    checkOutput("idle_clr_no_mc", 32'(mc_count - mc0), 32'd0);
    checkOutput("idle_clr_rdy", 32'(ifc.oIF_Rdy), 32'd1);

    // Clear mid-miss: fill silently, then hit
    mc0 = mc_count;
    applyStimulus(32'h200, 1'b0, 1'b0);
    checkOutput("clr_miss_req", 32'(mc_count - mc0), 32'd1);
    step();
    ifc.iClr = 1'b1;
    step();
    ifc.iClr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("drop_rdy_low", 32'(ifc.oIF_Rdy), 32'd0);
      if (i < 2) step();
    end
    mcReturn(32'h12345678, 1'b0, 1'b0);
    checkOutput("drop_rdy_back", 32'(ifc.oIF_Rdy), 32'd1);
    fetch(32'h200, 1'b0, 0);

    // Clear together with the return: line filled, no output
    mc0 = mc_count;
    applyStimulus(32'h308, 1'b0, 1'b0);
    checkOutput("clr_ret_req", 32'(mc_count - mc0), 32'd1);
    step();
    mcReturn(memval(32'h308), 1'b1, 1'b0);
    checkOutput("clr_ret_rdy", 32'(ifc.oIF_Rdy), 32'd1);
    fetch(32'h308, 1'b0, 0);

    // Flush invalidates a filled line
    fetch(32'h100, 1'b1, 2);
    ifc.iFlush = 1'b1;
    step();
    ifc.iFlush = 1'b0;
    fetch(32'h100, 1'b1, 2);

    // Flush coinciding with a fill: the filled line survives, others do not
    mc0 = mc_count;
    applyStimulus(32'h50C, 1'b0, 1'b1);
    checkOutput("flfill_req", 32'(mc_count - mc0), 32'd1);
    step();
    mcReturn(memval(32'h50C), 1'b0, 1'b1);
    checkOutput("flfill_drained", 32'(sb.size()), 32'd0);
    fetch(32'h50C, 1'b0, 0);
    fetch(32'h100, 1'b1, 1);

    // A return presented while en=0 is ignored
    mc0 = mc_count;
    applyStimulus(32'h610, 1'b0, 1'b1);
    checkOutput("stall_req", 32'(mc_count - mc0), 32'd1);
    step();
    en = 1'b0;
    ifc.iMC_En  = 1'b1;
    ifc.iMC_Ins = 32'hBAD0BAD0;
    step();
    step();
    en = 1'b1;
    ifc.iMC_En = 1'b0;
    checkOutput("stall_rdy", 32'(ifc.oIF_Rdy), 32'd0);
    checkOutput("stall_pending", 32'(sb.size()), 32'd1);
    step();
    mcReturn(memval(32'h610), 1'b0, 1'b0);
    checkOutput("stall_drained", 32'(sb.size()), 32'd0);
    fetch(32'h610, 1'b0, 0);

    // Asynchronous reset in the middle of a miss
    mc0 = mc_count;
    applyStimulus(32'h714, 1'b0, 1'b0);
    checkOutput("arst_req", 32'(mc_count - mc0), 32'd1);
    checkOutput("arst_pc_before", ifc.oMC_Pc, 32'h714);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_mc_en", 32'(ifc.oMC_En), 32'd0);
    checkOutput("arst_mc_pc", ifc.oMC_Pc, 32'd0);
    checkOutput("arst_if_ins", ifc.oIF_Ins, 32'd0);
    checkOutput("arst_if_en", 32'(ifc.oIF_En), 32'd0);
    checkOutput("arst_rdy", 32'(ifc.oIF_Rdy), 32'd1);
    step();
    rst = 1'b1;
    step();
    mcReturn(32'hCAFEF00D, 1'b0, 1'b0);
    step();
    checkOutput("stray_rdy", 32'(ifc.oIF_Rdy), 32'd1);
    fetch(32'h610, 1'b1, 1);

    step();
    checkOutput("final_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
